// File: rtl/aes_key_expansion.sv
// -----------------------------------------------------------------------------
// aes_key_expansion
//   AES key-schedule generator for AES-128/192/256, selected by KEY_BITS.
//   After start is sampled in IDLE, one 128-bit round key is presented per
//   clock: round key k appears in cycle k after the start edge (k = 1..Nr).
//   While idle, subkey shows round key 0, taken straight from the key input.
//
//   The key is held in an Nk-word window. Each cycle four new schedule words
//   are appended and the oldest four are dropped. The first four words of the
//   window are therefore always the round key being presented. At most one
//   word in any group of four needs SubWord, so a single 4-S-box unit serves
//   every key size.
//
// Ports
//   clk     in   1         rising-edge clock
//   reset   in   1         synchronous, active-low reset
//   start   in   1         sampled in IDLE; begins expansion of key
//   key     in   KEY_BITS  cipher key, word 0 in the most significant bits
//   subkey  out  128       current round key, w[4k] in [127:96]
//   busy    out  1         high while round keys 1..Nr are presented
// -----------------------------------------------------------------------------
module aes_key_expansion #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key,
  output logic [127:0]        subkey,
  output logic                busy
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;

  generate
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("aes_key_expansion: KEY_BITS must be 128, 192 or 256");
    end
  endgenerate

  // Forward S-box. Entry 0 is in the most significant byte.
  localparam logic [2047:0] SBOX_ROM = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x lives at bit offset (255 - x) * 8, and ~x equals 255 - x.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_ROM[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Multiply by x in GF(2^8). This steps Rcon from one value to the next.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_r;
  logic        busy_r;
  logic [3:0]  round_r;
  logic [2:0]  phase_r;        // index of the next word to generate, mod Nk
  logic [7:0]  rcon_r;         // Rcon for the next multiple-of-Nk word
  logic [31:0] win_r [NK];

  logic [31:0] src_win_s [NK];
  logic [2:0]  src_phase_s;
  logic [7:0]  src_rcon_s;
  logic        spec_hit_s;
  logic        spec_rot_s;
  logic [1:0]  spec_pos_s;
  logic [31:0] plain_s [3];
  logic [31:0] sub_in_s;
  logic [31:0] t_s;
  logic [31:0] gen_s [4];
  logic [31:0] nxt_win_s [NK];
  logic [2:0]  nxt_phase_s;
  logic [7:0]  nxt_rcon_s;

  // Generation source: the live key input in IDLE (start edge), otherwise the window.
  always_comb begin
    for (int q = 0; q < NK; q++) begin
      src_win_s[q] = 32'h0;
    end
    src_phase_s = 3'd0;
    src_rcon_s  = 8'h01;
    if (state_r == IDLE) begin
      for (int q = 0; q < NK; q++) begin
        src_win_s[q] = key[KEY_BITS-1-32*q -: 32];
      end
      src_phase_s = 3'd0;
      src_rcon_s  = 8'h01;
    end else begin
      for (int q = 0; q < NK; q++) begin
        src_win_s[q] = win_r[q];
      end
      src_phase_s = phase_r;
      src_rcon_s  = rcon_r;
    end
  end

  // Find the single word in this group of four that needs SubWord, if any.
  always_comb begin
    logic [3:0] sum_v;
    logic [3:0] pos_v;
    spec_hit_s = 1'b0;
    spec_rot_s = 1'b0;
    spec_pos_s = 2'd0;
    sum_v      = 4'd0;
    pos_v      = 4'd0;
    for (int q = 0; q < 4; q++) begin
      sum_v = {1'b0, src_phase_s} + 4'(q);
      pos_v = (sum_v >= 4'(NK)) ? (sum_v - 4'(NK)) : sum_v;
      if ((pos_v == 4'd0) || ((NK == 8) && (pos_v == 4'd4))) begin
        spec_hit_s = 1'b1;
        spec_rot_s = (pos_v == 4'd0);
        spec_pos_s = 2'(q);
      end else begin
        // ordinary word: t = w[i-1]
      end
    end
  end

  // Build four new words. The words before the special slot contain no
  // SubWord term, so a plain XOR chain gives the SubWord input without
  // routing it through the S-box output.
  always_comb begin
    logic [31:0] prev_v;
    sub_in_s = 32'h0;
    t_s      = 32'h0;
    prev_v   = src_win_s[NK-1];
    for (int q = 0; q < 3; q++) begin
      plain_s[q] = src_win_s[q] ^ prev_v;
      prev_v     = plain_s[q];
    end
    case (spec_pos_s)
      2'd1:    sub_in_s = plain_s[0];
      2'd2:    sub_in_s = plain_s[1];
      2'd3:    sub_in_s = plain_s[2];
      default: sub_in_s = src_win_s[NK-1];
    endcase
    if (spec_rot_s) begin
      t_s = sub_word({sub_in_s[23:0], sub_in_s[31:24]}) ^ {src_rcon_s, 24'h000000};
    end else begin
      t_s = sub_word(sub_in_s);
    end
    prev_v = src_win_s[NK-1];
    for (int q = 0; q < 4; q++) begin
      if (spec_hit_s && (spec_pos_s == 2'(q))) begin
        gen_s[q] = src_win_s[q] ^ t_s;
      end else begin
        gen_s[q] = src_win_s[q] ^ prev_v;
      end
      prev_v = gen_s[q];
    end
  end

  // Slide the window by four words and advance the phase and Rcon tracking.
  always_comb begin
    logic [3:0] ph_sum_v;
    for (int q = 0; q < NK; q++) begin
      nxt_win_s[q] = 32'h0;
    end
    for (int q = 0; q < NK - 4; q++) begin
      nxt_win_s[q] = src_win_s[q+4];
    end
    for (int q = 0; q < 4; q++) begin
      nxt_win_s[NK-4+q] = gen_s[q];
    end
    ph_sum_v    = {1'b0, src_phase_s} + 4'd4;
    nxt_phase_s = (ph_sum_v >= 4'(NK)) ? 3'(ph_sum_v - 4'(NK)) : ph_sum_v[2:0];
    nxt_rcon_s  = (spec_hit_s && spec_rot_s) ? xtime(src_rcon_s) : src_rcon_s;
  end

  // Control FSM and key-window registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      round_r <= 4'd0;
      phase_r <= 3'd0;
      rcon_r  <= 8'h00;
      for (int q = 0; q < NK; q++) begin
        win_r[q] <= 32'h0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
            round_r <= 4'd1;
            phase_r <= nxt_phase_s;
            rcon_r  <= nxt_rcon_s;
            for (int q = 0; q < NK; q++) begin
              win_r[q] <= nxt_win_s[q];
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        RUN: begin
          if (round_r == 4'(NR)) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            round_r <= 4'd0;
          end else begin
            busy_r  <= 1'b1;
            round_r <= round_r + 4'd1;
            phase_r <= nxt_phase_s;
            rcon_r  <= nxt_rcon_s;
            for (int q = 0; q < NK; q++) begin
              win_r[q] <= nxt_win_s[q];
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          round_r <= 4'd0;
        end
      endcase
    end
  end

  assign subkey = (state_r == RUN) ? {win_r[0], win_r[1], win_r[2], win_r[3]}
                                   : key[KEY_BITS-1 -: 128];
  assign busy   = busy_r;

endmodule

// File: tb/tb_aes_key_expansion.sv
// -----------------------------------------------------------------------------
// tb_aes_key_expansion
//   Bench for aes_key_expansion with one instance per key size. Keys are held
//   left-justified in 256-bit variables. Expected round keys come from a
//   word-array model of the key schedule. The model's S-box is derived from
//   the GF(2^8) inverse and the affine map.
// -----------------------------------------------------------------------------
module tb_aes_key_expansion;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   start_v;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic [127:0] subkey_a [3];
  logic [2:0]   busy_v;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_rk [15];
  logic [127:0] cap [16];
  logic         bz [16];

  typedef struct {
    int           sz;
    logic [255:0] key;
    int           cyc;
    logic [127:0] exp_sk;
    logic         exp_busy;
  } kat_t;
  kat_t kats [13];

  always #5 clk = ~clk;

  aes_key_expansion #(.KEY_BITS(128)) dut128 (
    .clk(clk), .reset(reset), .start(start_v[0]), .key(key128),
    .subkey(subkey_a[0]), .busy(busy_v[0]));
  aes_key_expansion #(.KEY_BITS(192)) dut192 (
    .clk(clk), .reset(reset), .start(start_v[1]), .key(key192),
    .subkey(subkey_a[1]), .busy(busy_v[1]));
  aes_key_expansion #(.KEY_BITS(256)) dut256 (
    .clk(clk), .reset(reset), .start(start_v[2]), .key(key256),
    .subkey(subkey_a[2]), .busy(busy_v[2]));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^
                    rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] m_subword(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_of(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int j = 1; j < n; j++) r = gmul(r, 8'h02);
    return r;
  endfunction

  function automatic void compute_schedule(input int nk, input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    int total;
    total = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < total; i++) begin
      t = w[i-1];
      if (i % nk == 0)
        t = m_subword({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
      else if (nk == 8 && i % 8 == 4)
        t = m_subword(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < nk + 7; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // ---------------- helpers ----------------
  function automatic int nk_of(input int sz);
    return (sz == 0) ? 4 : (sz == 1) ? 6 : 8;
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  task automatic set_key(input int sz, input logic [255:0] k);
    case (sz)
      0:       key128 = k[255:128];
      1:       key192 = k[255:64];
      default: key256 = k;
    endcase
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Start an expansion from the current cycle (entered at posedge+1) and
  // capture cycles 0..Nr+1. Optionally inject a re-start with a new key at
  // cycle inj_cyc, and optionally check the whole run against the model.
  task automatic run_exp(input int sz, input logic [255:0] k, input int inj_cyc,
                         input logic [255:0] k2, input logic chk_model);
    int nr;
    logic [255:0] cur;
    nr  = nk_of(sz) + 6;
    cur = k;
    set_key(sz, k);
    start_v[sz] = 1'b1;
    #1;
    cap[0] = subkey_a[sz];
    bz[0]  = busy_v[sz];
    for (int c = 1; c <= nr + 1; c++) begin
      @(posedge clk);
      #1;
      start_v[sz] = 1'b0;
      if (c == inj_cyc) begin
        set_key(sz, k2);
        cur = k2;
        start_v[sz] = 1'b1;
      end
      cap[c] = subkey_a[sz];
      bz[c]  = busy_v[sz];
    end
    if (chk_model) begin
      compute_schedule(nk_of(sz), k);
      for (int c = 0; c <= nr; c++) begin
        chk($sformatf("rk sz=%0d cyc=%0d", sz, c), cap[c], exp_rk[c]);
        chk($sformatf("busy sz=%0d cyc=%0d", sz, c), {127'h0, bz[c]},
            {127'h0, (c >= 1) ? 1'b1 : 1'b0});
      end
      chk($sformatf("done busy sz=%0d", sz), {127'h0, bz[nr+1]}, 128'h0);
      chk($sformatf("done subkey sz=%0d", sz), cap[nr+1], cur[255:128]);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [255:0] k;
    logic [255:0] k2;

    kats[0]  = '{0, K128, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0};
    kats[1]  = '{0, K128, 1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b1};
    kats[2]  = '{0, K128, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1};
    kats[3]  = '{0, K128, 11, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0};
    kats[4]  = '{1, K192, 0,  128'h8e73b0f7da0e6452c810f32b809079e5, 1'b0};
    kats[5]  = '{1, K192, 1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5, 1'b1};
    kats[6]  = '{1, K192, 12, 128'he98ba06f448c773c8ecc720401002202, 1'b1};
    kats[7]  = '{1, K192, 13, 128'h8e73b0f7da0e6452c810f32b809079e5, 1'b0};
    kats[8]  = '{2, K256, 0,  128'h603deb1015ca71be2b73aef0857d7781, 1'b0};
    kats[9]  = '{2, K256, 1,  128'h1f352c073b6108d72d9810a30914dff4, 1'b1};
    kats[10] = '{2, K256, 2,  128'h9ba354118e6925afa51a8b5f2067fcde, 1'b1};
    kats[11] = '{2, K256, 14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b1};
    kats[12] = '{2, K256, 15, 128'h603deb1015ca71be2b73aef0857d7781, 1'b0};

    build_sbox();

    reset   = 1'b0;
    start_v = 3'b000;
    set_key(0, K128);
    set_key(1, K192);
    set_key(2, K256);
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {125'h0, busy_v}, 128'h0);
    chk("reset subkey 128", subkey_a[0], K128[255:128]);
    chk("reset subkey 192", subkey_a[1], K192[255:128]);
    chk("reset subkey 256", subkey_a[2], K256[255:128]);
    reset = 1'b1;

    // Known-answer table.
    for (int i = 0; i < 13; i++) begin
      run_exp(kats[i].sz, kats[i].key, 0, 256'h0, 1'b0);
      chk($sformatf("kat%0d subkey", i), cap[kats[i].cyc], kats[i].exp_sk);
      chk($sformatf("kat%0d busy", i), {127'h0, bz[kats[i].cyc]}, {127'h0, kats[i].exp_busy});
    end

    // Full-run check of the spec keys, then random keys for each size.
    run_exp(0, K128, 0, 256'h0, 1'b1);
    run_exp(1, K192, 0, 256'h0, 1'b1);
    run_exp(2, K256, 0, 256'h0, 1'b1);
    for (int sz = 0; sz < 3; sz++) begin
      for (int n = 0; n < 3; n++) begin
        run_exp(sz, rand_key(), 0, 256'h0, 1'b1);
      end
    end

    // Reset at cycle 5 of a 128 run aborts; a new start reproduces the schedule.
    compute_schedule(4, K128);
    set_key(0, K128);
    start_v[0] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      chk($sformatf("pre-abort rk cyc=%0d", c), subkey_a[0], exp_rk[c]);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("abort busy", {127'h0, busy_v[0]}, 128'h0);
    chk("abort subkey", subkey_a[0], K128[255:128]);
    run_exp(0, K128, 0, 256'h0, 1'b1);

    // Re-start plus key change in RUN are ignored; back-to-back start with a new key.
    k2 = rand_key();
    run_exp(0, K128, 3, k2, 1'b1);
    run_exp(0, rand_key(), 0, 256'h0, 1'b1);
    k2 = rand_key();
    run_exp(2, K256, 6, k2, 1'b1);
    run_exp(2, rand_key(), 0, 256'h0, 1'b1);

    // Idle after reset: busy stays low and subkey follows the key input.
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      k = rand_key();
      set_key(0, k);
      set_key(2, k);
      #1;
      chk($sformatf("idle subkey128 c=%0d", c), subkey_a[0], k[255:128]);
      chk($sformatf("idle subkey256 c=%0d", c), subkey_a[2], k[255:128]);
      chk($sformatf("idle busy c=%0d", c), {126'h0, busy_v[2], busy_v[0]}, 128'h0);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_expansion.md
Name: aes_key_expansion

Overview:
- Parameterised AES key-schedule generator (FIPS-197) covering AES-128/192/256 via KEY_BITS.
- Three instances (one per key size) sit under the key-expansion wrapper. The wrapper pulses start, then captures one 128-bit round key per clock into its round-key memory.
- Produces one full round key (4 words) per cycle after start, so round keys stream out back-to-back.

Parameters:
- KEY_BITS, 128, cipher key size. Legal values are 128, 192 or 256; any other value is a compile-time error. Nk = KEY_BITS/32; Nr = Nk+6; NRK = Nr+1 round keys (11/13/15).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- start  input  1  one-cycle request to begin expansion of key
- key  input  KEY_BITS  cipher key; w0 = key[KEY_BITS-1 -: 32] (FIPS byte order, MSB first)
- subkey  output  128  current round key; w[4i] in [127:96] … w[4i+3] in [31:0]
- busy  output  1  high while round keys 1..Nr are being streamed

Behaviour:
- Reset: reset==0 sampled at a clk edge forces state IDLE, round index 0, busy=0, and clears the word window. Reset mid-run aborts immediately. No partial keys persist.
- IDLE:
  - subkey is combinational round key 0, i.e. key[KEY_BITS-1 -: 128].
  - busy=0.
- start handling:
  - start sampled high in IDLE latches key into an internal Nk-word window.
  - Next state is RUN with round index 1. start is a level sample; no acknowledge.
  - The cycle in which start is sampled therefore still shows round key 0 on subkey.
- RUN:
  - Cycle k after the start edge (k=1..Nr): subkey = round key k (registered); busy=1.
  - Each cycle generates 4 new words w[i] = w[i-Nk] XOR t, where:
    - t = SubWord(RotWord(w[i-1])) XOR Rcon[i/Nk] when i mod Nk == 0;
    - t = SubWord(w[i-1]) when Nk==8 and i mod 8 == 4;
    - otherwise t = w[i-1].
  - At most one special word occurs per 4-word group for every Nk. One SubWord unit (4 S-boxes) plus a sliding Nk-word window therefore suffices.
  - Rcon = 01,02,04,08,10,20,40,80,1b,36 in the top byte.
- Completion:
  - After the cycle presenting round key Nr, the state returns to IDLE and busy drops to 0.
  - subkey then reverts to round key 0 of the current key input.
  - Total run length: Nr cycles after the start edge (10/12/14).
- start while RUN: ignored. key changes during RUN: ignored (latched copy used).
- Back-to-back: start sampled in the first IDLE cycle after completion begins a new expansion normally.
- The consumer captures subkey on every edge from the start edge through cycle Nr, giving NRK consecutive round keys.
- S-box: standard AES forward S-box, combinational (case/ROM), shared across all key sizes.

Test Plan:
- 128: key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle.
  - Start cycle: subkey = key.
  - Cycle 1: a0fafe1788542cb123a339392a6c7605.
  - Cycle 10: d014f9a8c9ee2589e13f0cc8b6630ca6.
  - busy=1 for exactly cycles 1..10.
- 192: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
  - Start cycle: 8e73b0f7da0e6452c810f32b809079e5.
  - Cycle 1: 62f8ead2522c6b7bfe0c91f72402f5a5.
  - Cycle 12: e98ba06f448c773c8ecc720401002202.
  - busy low from cycle 13.
- 256: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
  - Start cycle: 603deb1015ca71be2b73aef0857d7781.
  - Cycle 1: 1f352c073b6108d72d9810a30914dff4.
  - Cycle 2: 9ba354118e6925afa51a8b5f2067fcde.
  - Cycle 14: fe4890d1e6188d0b046df344706c631e.
- Reset at cycle 5 of a 128 run: busy=0 next edge, subkey = key input. A new start then reproduces the full sequence from cycle 1.
- Re-start and key change during RUN (128 vector): both ignored and the sequence is unchanged. A start immediately after completion with a new key produces the new schedule.
- Idle after reset with start=0 for 20 cycles: busy stays 0 and subkey tracks the key input combinationally.
